// File: rtl/wbp2classic.sv
// Wishbone pipelined-slave to classic-master bridge: requests are queued in a
// small FIFO and replayed one at a time as classic strobe/ack cycles.
module wbp2classic #(
    parameter int AW     = 12,
    parameter int DW     = 32,
    parameter int LGFIFO = 2
) (
    input  logic            i_clk,
    input  logic            i_reset,
    // Pipelined (upstream) side
    input  logic            i_scyc,
    input  logic            i_sstb,
    input  logic            i_swe,
    input  logic [AW-1:0]   i_saddr,
    input  logic [DW-1:0]   i_sdata,
    input  logic [DW/8-1:0] i_ssel,
    output logic            o_sstall,
    output logic            o_sack,
    output logic [DW-1:0]   o_sdata,
    output logic            o_serr,
    // Classic (downstream) side
    output logic            o_mcyc,
    output logic            o_mstb,
    output logic            o_mwe,
    output logic [AW-1:0]   o_maddr,
    output logic [DW-1:0]   o_mdata,
    output logic [DW/8-1:0] o_msel,
    output logic [2:0]      o_mcti,
    output logic [1:0]      o_mbte,
    input  logic            i_mack,
    input  logic            i_merr,
    input  logic [DW-1:0]   i_mdata,
    // Debug view of the transaction FSM
    output logic [1:0]      o_dbg_state
);

    localparam int SW    = DW / 8;
    localparam int FW    = 1 + AW + DW + SW;
    localparam int DEPTH = 1 << LGFIFO;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] BUSY    = 2'd1;
    localparam logic [1:0] ERRHOLD = 2'd2;

    logic [1:0]      state, state_nxt;
    logic [FW-1:0]   fifo_mem [0:DEPTH-1];
    logic [FW-1:0]   fifo_head;
    logic [LGFIFO:0] wr_ptr, rd_ptr;
    logic            fifo_full, fifo_empty;
    logic            push, pop, flush, retire, raise_err;

    // Handshake: upstream request transfers on a cycle with i_scyc && i_sstb
    // && !o_sstall; downstream transfer completes on any cycle o_mstb is high
    // and i_mack (or i_merr) is sampled high.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = ((wr_ptr ^ rd_ptr) == {1'b1, {LGFIFO{1'b0}}});
    assign fifo_head  = fifo_mem[rd_ptr[LGFIFO-1:0]];

    // Stall uses the registered count only, so a same-cycle pop never frees a slot early
    assign o_sstall   = fifo_full || (state == ERRHOLD);
    assign push       = i_scyc && i_sstb && !o_sstall;

    assign o_mcti      = 3'b000;
    assign o_mbte      = 2'b00;
    assign o_dbg_state = state;

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        flush     = 1'b0;
        retire    = 1'b0;
        raise_err = 1'b0;
        if (!i_scyc) begin
            flush     = 1'b1;
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        pop       = 1'b1;
                        state_nxt = BUSY;
                    end
                end
                BUSY: begin
                    if (i_merr) begin
                        flush     = 1'b1;
                        raise_err = 1'b1;
                        state_nxt = ERRHOLD;
                    end else if (i_mack) begin
                        retire = 1'b1;
                        if (!fifo_empty) begin
                            pop = 1'b1;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end
                end
                ERRHOLD: begin
                    state_nxt = ERRHOLD;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // A flush also discards any request pushed on the same edge
    always_ff @(posedge i_clk) begin
        if (i_reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_mem[wr_ptr[LGFIFO-1:0]] <= {i_swe, i_saddr, i_sdata, i_ssel};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state   <= IDLE;
            o_sack  <= 1'b0;
            o_serr  <= 1'b0;
            o_sdata <= '0;
            o_mcyc  <= 1'b0;
            o_mstb  <= 1'b0;
            o_mwe   <= 1'b0;
            o_maddr <= '0;
            o_mdata <= '0;
            o_msel  <= '0;
        end else begin
            state  <= state_nxt;
            o_sack <= retire;
            o_serr <= raise_err;
            if (retire) begin
                o_sdata <= i_mdata;
            end
            if (pop) begin
                o_mcyc <= 1'b1;
                o_mstb <= 1'b1;
                {o_mwe, o_maddr, o_mdata, o_msel} <= fifo_head;
            end else if (state_nxt != BUSY) begin
                o_mcyc <= 1'b0;
                o_mstb <= 1'b0;
            end
        end
    end

endmodule

// File: doc/wbp2classic.md
# wbp2classic

Bridges a Wishbone pipelined master onto a Wishbone classic slave, the reverse of the classic-to-pipelined bridge in the bus-bridge library. Pipelined requests are accepted into a small request FIFO and issued one at a time as classic strobe/ack transactions. Responses return to the pipelined side in order, one `o_sack` per accepted request. The block sits between a pipelined interconnect and legacy classic peripherals.

## Interface
- `AW`, 12, address width (words)
- `DW`, 32, data width; `DW/8` select lines
- `LGFIFO`, 2, log2 request FIFO depth (depth `2**LGFIFO`, ≥2)

- `i_clk` in 1, clock
- `i_reset` in 1, reset i_reset, synchronous, active-high; clock i_clk
- `i_scyc`, `i_sstb`, `i_swe` in 1, upstream pipelined request
- `i_saddr` in AW, `i_sdata` in DW, `i_ssel` in DW/8, request fields
- `o_sstall` out 1, upstream stall
- `o_sack` out 1, upstream ack
- `o_sdata` out DW, upstream read data
- `o_serr` out 1, upstream bus error
- `o_mcyc`, `o_mstb`, `o_mwe` out 1, downstream classic request
- `o_maddr` out AW, `o_mdata` out DW, `o_msel` out DW/8, downstream fields
- `o_mcti` out 3, constant 3'b000 (classic cycle)
- `o_mbte` out 2, constant 2'b00
- `i_mack`, `i_merr` in 1, downstream ack/error
- `i_mdata` in DW, downstream read data

## Operation
- Accept: `i_scyc && i_sstb && !o_sstall` pushes {we, addr, data, sel} into FIFO.
- `o_sstall` = FIFO full (registered count) OR error-hold state; full FIFO stalls even if a pop happens the same cycle.
- States: IDLE, BUSY (classic transaction in flight), ERRHOLD.
- IDLE: FIFO non-empty and `i_scyc` → pop head into registered `o_m*` fields, `o_mcyc=o_mstb=1`, go BUSY.
- BUSY: hold all `o_m*` stable until `i_mack` or `i_merr`.
  - `i_mack`: `o_sack<=1` next cycle, `o_sdata<=i_mdata` (writes too). Same edge: FIFO non-empty → pop next entry, stay BUSY (back-to-back strobes allowed); else `o_mcyc=o_mstb<=0`, IDLE.
  - `i_merr` (wins over `i_mack`): `o_serr<=1` for one cycle, no `o_sack`, flush FIFO, drop `o_mcyc/o_mstb`, go ERRHOLD.
- ERRHOLD: `o_sstall=1`, no requests issued; leave to IDLE when `i_scyc` low.
- `i_scyc` low in any state: flush FIFO, next edge `o_mcyc=o_mstb=0`, suppress `o_sack/o_serr`, any late `i_mack/i_merr` ignored, go IDLE.
- `i_mack/i_merr` in IDLE/ERRHOLD ignored.
- Exactly one `o_sack` or the single `o_serr` per accepted request; order preserved.

## Timing
- Reset: `o_mcyc=o_mstb=o_mwe=0`, `o_sack=o_serr=0`, `o_sstall=0`, FIFO empty, IDLE; `o_maddr/o_mdata/o_msel/o_sdata` zeroed.
- Request accepted cycle N (FIFO empty, IDLE) → `o_mstb` high cycle N+2.
- `i_mack` in cycle M → `o_sack` high cycle M+1 only; next queued request strobed in M+1.
- Minimum round trip with zero-wait slave: 4 cycles accept-to-ack; sustained one ack per cycle when slave acks each strobe same cycle.
- FIFO pointers LGFIFO+1 bits, wrap modulo 2**LGFIFO; full when pointers differ only in MSB.
- `o_sack`, `o_serr` never high together; never high while `i_scyc` was low the previous cycle.

## Test plan
- Single write: accept addr 0x010 data 0xDEADBEEF sel 4'hF at N, slave acks on first stb → `o_mstb` at N+2 with those fields, `o_sack` at N+3, one pulse.
- Burst of 4 reads, slave acks 1-cycle-late, returns 0x1..0x4 → `o_sstall` high once FIFO holds 4 unissued, four `o_sack` in order with `o_sdata` 0x1,0x2,0x3,0x4.
- Zero-wait slave, 3 queued writes → strobes in three consecutive cycles, `o_mcyc` continuous, 3 consecutive `o_sack`.
- Error on 2nd of 3 reads → one `o_sack`, one `o_serr`, third never strobed, `o_sstall` high until `i_scyc` drops, then 0.
- `i_scyc` dropped mid-transaction with 2 queued, slave acks one cycle later → `o_mcyc=0` next cycle, no `o_sack`, FIFO empty, new cycle works normally.
- `i_reset` asserted while BUSY → all outputs at reset values next cycle, FIFO empty.
